dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, width of the transfer-length register and counter in words.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cs input 1, wr input 1, addr input 32, wdata input 32, rdata output 32; these form the peripheral config port. Only addr[3:2] is decoded. Read data is combinational.
REQ-005 SHALL have ports: mReq output 1, mGnt input 1, mAddr output 32, mWdata output 32, mWe output 1, mBHW output 2, mRdata input 32; these form the bus-master port.
REQ-006 SHALL have port: irq  output  1  transfer-complete interrupt.

Function
REQ-007 SHALL map registers as follows: 0x0 SRC (32b), 0x4 DST (32b), 0x8 LEN (CNT_W b, upper bits read 0), 0xC CTRL/STAT.
REQ-008 SHALL handle CTRL writes as follows: bit0=start, bit1=done-clear, bit2=abort, bit3=ie. CTRL reads return: bit0=busy, bit1=done, bit3=ie, all other bits 0.
REQ-009 SHALL capture a config write on the rising edge where cs=1 and wr=1; writes to SRC/DST/LEN while busy SHALL be ignored.
REQ-010 SHALL implement FSM states IDLE, RD, WR, DONE; busy=1 in RD and WR.
REQ-011 SHALL make transitions on a start write in IDLE as follows: LEN=0 goes directly to DONE with no bus access; otherwise load working src/dst/count and go to RD on the next edge.
REQ-012 SHALL, in RD: drive mReq=1, mWe=0, mAddr=src; on an edge with mGnt=1, latch mRdata into the data buffer and go to WR. With mGnt=0 it SHALL hold all outputs.
REQ-013 SHALL, in WR: drive mReq=1, mWe=1, mAddr=dst, mWdata=buffer; on an edge with mGnt=1, set src+=4, dst+=4, count-=1, then go to RD if count after decrement is nonzero, else go to DONE.
REQ-014 SHALL, in DONE: set the done flag and return to IDLE on the next edge.
REQ-015 SHALL drive mBHW constant 2'b10 (word access), and drive mReq=0, mWe=0, mAddr=0, mWdata=0 in IDLE/DONE.
REQ-016 SHALL need a minimum of 2 cycles per word with mGnt held high; LEN=N SHALL take 2N cycles from the first RD cycle to DONE.
REQ-017 SHALL wrap src/dst addresses modulo 2^32.
REQ-018 SHALL ignore a start write while busy.
REQ-019 SHALL, on an abort write while busy: go to IDLE on the next edge, leave done unset, and suppress any pending write. An abort while idle SHALL have no effect.
REQ-020 SHALL give precedence when start and done-clear arrive in the same write: done is cleared, then the transfer starts. If done-clear and the DONE state occur on the same edge, done SHALL be set.
REQ-021 SHALL NOT alter the SRC/DST/LEN registers during a transfer; a readback SHALL return the programmed values.

Reset
REQ-022 SHALL, while reset=0, asynchronously force: state=IDLE; SRC, DST, LEN, ie, done, buffer and counters = 0; mReq=0; mWe=0; mAddr=0; mWdata=0; irq=0.
REQ-023 SHALL, when reset is asserted mid-transfer, drop mReq within the reset assertion with no completing write, and resume in IDLE after deassertion.

Configuration
REQ-024 SHALL, with macro DMA_IRQ_EN defined, drive irq = done AND ie as a registered level, cleared by done-clear or by a new start.
REQ-025 SHALL, without DMA_IRQ_EN, tie irq to 0, ignore writes to ie, and read ie as 0; all other behaviour SHALL be unchanged.

Verification
REQ-026 SHALL pass this scenario: with SRC=0x200, DST=0x240, LEN=4, mGnt=1, and a memory model, DST words equal the SRC words, done=1 after 8 bus cycles plus 1, and busy=0.
REQ-027 SHALL pass this scenario: with LEN=0 and start written, mReq never asserts and done=1 on the second edge after the write.
REQ-028 SHALL pass this scenario: with mGnt held 0 for 5 cycles during RD, mAddr stays 0x200 and mReq stays 1; the transfer completes correctly once mGnt=1.
REQ-029 SHALL pass this scenario: an abort written during the WR of word 2 of LEN=4 gives exactly 1 completed write, done=0, and busy=0 on the next edge.
REQ-030 SHALL pass this scenario: with DMA_IRQ_EN defined and ie=1, irq=1 after completion, and irq=0 one edge after a done-clear; with the macro undefined, irq stays 0 throughout.
REQ-031 SHALL pass this scenario: with SRC=0xFFFFFFFC, LEN=2, the second read address is 0x00000000.

Source files
------------

// File: rtl/dma_engine.sv
// dma_engine: single-channel, word-granular memory-to-memory DMA.
// A peripheral config port programs SRC/DST/LEN and CTRL. The bus-master
// port moves one word per RD/WR pair.
// Optional feature: define DMA_IRQ_EN to enable the transfer-complete
// interrupt (irq = done & ie). Without it, irq is tied low and ie reads as 0.
module dma_engine #(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mReq,
    input  logic        mGnt,
    output logic [31:0] mAddr,
    output logic [31:0] mWdata,
    output logic        mWe,
    output logic [1:0]  mBHW,
    input  logic [31:0] mRdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           state;
    logic [31:0]      src_reg;
    logic [31:0]      dst_reg;
    logic [CNT_W-1:0] len_reg;
    logic [31:0]      work_src;
    logic [31:0]      work_dst;
    logic [CNT_W-1:0] work_cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic [31:0]      data_buf;
    logic             done;
    logic             done_next;
    logic             ie;
    logic             busy;
    logic             cfg_wr;
    logic             ctrl_wr;
    logic             start_cmd;
    logic             clear_cmd;
    logic             abort_cmd;
    logic             unused_addr;

    assign cfg_wr    = cs & wr;
    assign ctrl_wr   = cfg_wr && (addr[3:2] == 2'd3);
    assign start_cmd = ctrl_wr & wdata[0];
    assign clear_cmd = ctrl_wr & wdata[1];
    assign abort_cmd = ctrl_wr & wdata[2];
    assign busy      = (state == RD) || (state == WR);
    assign cnt_dec   = work_cnt - CNT_W'(1);

    // Only word accesses are issued; write data is the registered buffer,
    // which is kept at zero outside the WR state.
    assign mBHW   = 2'b10;
    assign mWdata = data_buf;

    // Address bits outside [3:2] are not decoded.
    assign unused_addr = &{1'b0, addr[31:4], addr[1:0]};

    // Programmed registers; frozen while a transfer is running so readback
    // always shows what software wrote.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
        end else if (cfg_wr && !busy) begin
            case (addr[3:2])
                2'd0:    src_reg <= wdata;
                2'd1:    dst_reg <= wdata;
                2'd2:    len_reg <= wdata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Next value of the done flag: clear/start drop it, reaching DONE wins.
    always_comb begin
        done_next = done;
        if (clear_cmd) begin
            done_next = 1'b0;
        end
        if ((state == IDLE) && start_cmd) begin
            done_next = 1'b0;
        end
        if (state == DONE) begin
            done_next = 1'b1;
        end
    end

`ifdef DMA_IRQ_EN
    logic ie_next;

    // A CTRL write always rewrites the interrupt enable.
    always_comb begin
        ie_next = ctrl_wr ? wdata[3] : ie;
    end

    // Interrupt enable and registered interrupt level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            ie  <= ie_next;
            irq <= done_next & ie_next;
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // Transfer sequencer with registered bus-master outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            work_src <= '0;
            work_dst <= '0;
            work_cnt <= '0;
            data_buf <= '0;
            done     <= 1'b0;
            mReq     <= 1'b0;
            mWe      <= 1'b0;
            mAddr    <= '0;
        end else begin
            done <= done_next;
            if (busy && abort_cmd) begin
                // Abort drops the bus immediately; a pending write never issues.
                state    <= IDLE;
                data_buf <= '0;
                mReq     <= 1'b0;
                mWe      <= 1'b0;
                mAddr    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_cmd) begin
                            if (len_reg == '0) begin
                                state <= DONE;
                            end else begin
                                work_src <= src_reg;
                                work_dst <= dst_reg;
                                work_cnt <= len_reg;
                                state    <= RD;
                                mReq     <= 1'b1;
                                mWe      <= 1'b0;
                                mAddr    <= src_reg;
                            end
                        end
                    end
                    RD: begin
                        if (mGnt) begin
                            data_buf <= mRdata;
                            state    <= WR;
                            mWe      <= 1'b1;
                            mAddr    <= work_dst;
                        end
                    end
                    WR: begin
                        if (mGnt) begin
                            work_src <= work_src + 32'd4;
                            work_dst <= work_dst + 32'd4;
                            work_cnt <= cnt_dec;
                            data_buf <= '0;
                            if (cnt_dec != '0) begin
                                state <= RD;
                                mWe   <= 1'b0;
                                mAddr <= work_src + 32'd4;
                            end else begin
                                state <= DONE;
                                mReq  <= 1'b0;
                                mWe   <= 1'b0;
                                mAddr <= '0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Combinational register readback.
    always_comb begin
        case (addr[3:2])
            2'd0:    rdata = src_reg;
            2'd1:    rdata = dst_reg;
            2'd2:    rdata = {{(32-CNT_W){1'b0}}, len_reg};
            default: rdata = {28'd0, ie, 1'b0, done, busy};
        endcase
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed and randomized checks of dma_engine against a
// word-copy reference model with a 256-word memory behind the master port.
module tb_dma_engine;

    localparam int CNT_W = 8;
`ifdef DMA_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        mReq;
    logic        mGnt = 1'b0;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic        mWe;
    logic [1:0]  mBHW;
    logic [31:0] mRdata;
    logic        irq;

    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    int          req_seen = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        ie_sh = 1'b0;

    dma_engine #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .mReq(mReq), .mGnt(mGnt),
        .mAddr(mAddr), .mWdata(mWdata), .mWe(mWe), .mBHW(mBHW),
        .mRdata(mRdata), .irq(irq)
    );

    always #50 clk = ~clk;

    assign mRdata = mem[mAddr[9:2]];

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[9:2];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: sample the bus just after the falling edge (inputs stable
    // until the next rising edge), apply the slave side, then wait a cycle.
    task automatic tick();
        #1;
        if (mReq && mGnt) begin
            if (mWe) begin
                mem[widx(mAddr)] = mWdata;
                wr_q.push_back(mAddr);
            end else begin
                rd_q.push_back(mAddr);
            end
        end
        if (mReq) req_seen++;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        addr = a; cs = 1'b1; wr = 1'b0;
        #1;
        v = rdata;
        cs = 1'b0;
    endtask

    task automatic prog(input logic [31:0] s, input logic [31:0] d, input int n);
        cfg_write(32'h0, s);
        cfg_write(32'h4, d);
        cfg_write(32'h8, 32'(n));
    endtask

    task automatic start_xfer();
        cfg_write(32'hC, {28'd0, ie_sh, 3'b011});
    endtask

    task automatic fill_and_snapshot();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        exp_mem = mem;
        rd_q.delete(); wr_q.delete(); exp_rd.delete(); exp_wr.delete();
    endtask

    // Reference: copy n words one after another, addresses wrap mod 2^32.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa;
        logic [31:0] da;
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            exp_mem[widx(da)] = exp_mem[widx(sa)];
            exp_rd.push_back(sa);
            exp_wr.push_back(da);
        end
    endtask

    task automatic check_result(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({tag, "_mem"}, 32'(bad), 32'd0);
        check({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        bad = 0;
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) if (rd_q[i] !== exp_rd[i]) bad++;
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) if (wr_q[i] !== exp_wr[i]) bad++;
        check({tag, "_addrs"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_done(input bit rnd, output int cyc);
        logic [31:0] st;
        cyc = 0;
        rd_reg(32'hC, st);
        while (!st[1] && cyc < 2000) begin
            mGnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
            rd_reg(32'hC, st);
        end
        check("completion", 32'(st[1]), 32'd1);
    endtask

    task automatic check_status(input string tag, input logic busy_w, input logic done_w);
        logic [31:0] st;
        rd_reg(32'hC, st);
        check({tag, "_ctrl"}, st, {28'd0, IRQ_ON & ie_sh, 1'b0, done_w, busy_w});
        check({tag, "_irq"}, 32'(irq), 32'(IRQ_ON & ie_sh & done_w));
    endtask

    initial begin
        logic [31:0] v;
        int          cyc;
        logic [31:0] s;
        logic [31:0] d;
        int          n;
        bit          rnd;

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mReq", 32'(mReq), 32'd0);
        check("rst_mWe", 32'(mWe), 32'd0);
        check("rst_mAddr", mAddr, 32'd0);
        check("rst_mWdata", mWdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_mBHW", 32'(mBHW), 32'd2);
        for (int r = 0; r < 4; r++) begin
            rd_reg(32'(r * 4), v);
            check("rst_reg", v, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Basic 4-word copy with grant always high
        ie_sh = 1'b1;
        fill_and_snapshot();
        prog(32'h200, 32'h240, 4);
        model_copy(32'h200, 32'h240, 4);
        mGnt = 1'b1;
        start_xfer();
        rd_reg(32'hC, v);
        check("a_busy", 32'(v[0]), 32'd1);
        check("a_mReq", 32'(mReq), 32'd1);
        check("a_mAddr", mAddr, 32'h200);
        wait_done(1'b0, cyc);
        check("a_cycles", 32'(cyc), 32'd9);
        check_status("a_end", 1'b0, 1'b1);
        check_result("a");
        rd_reg(32'h0, v); check("a_src_rb", v, 32'h200);
        rd_reg(32'h4, v); check("a_dst_rb", v, 32'h240);
        rd_reg(32'h8, v); check("a_len_rb", v, 32'd4);
        cfg_write(32'hC, {28'd0, ie_sh, 3'b010});
        check_status("a_clr", 1'b0, 1'b0);

        // Zero length: straight to done, no bus traffic
        prog(32'h200, 32'h240, 0);
        req_seen = 0;
        start_xfer();
        check_status("z_edge1", 1'b0, 1'b0);
        tick();
        check_status("z_edge2", 1'b0, 1'b1);
        check("z_noreq", 32'(req_seen), 32'd0);
        cfg_write(32'hC, {28'd0, ie_sh, 3'b100});
        check_status("z_idle_abort", 1'b0, 1'b1);
        cfg_write(32'hC, {28'd0, ie_sh, 3'b010});

        // Grant withheld for 5 cycles in the first read
        fill_and_snapshot();
        prog(32'h200, 32'h300, 3);
        model_copy(32'h200, 32'h300, 3);
        mGnt = 1'b0;
        start_xfer();
        for (int k = 0; k < 5; k++) begin
            check("s_hold_req", 32'(mReq), 32'd1);
            check("s_hold_addr", mAddr, 32'h200);
            tick();
        end
        wait_done(1'b0, cyc);
        check("s_cycles", 32'(cyc), 32'd7);
        check_result("s");
        cfg_write(32'hC, {28'd0, ie_sh, 3'b010});

        // Abort during the write of word 2
        fill_and_snapshot();
        prog(32'h200, 32'h240, 4);
        model_copy(32'h200, 32'h240, 1);
        exp_rd.push_back(32'h204);
        mGnt = 1'b1;
        start_xfer();
        repeat (3) tick();
        check("ab_inwr", 32'(mWe), 32'd1);
        check("ab_wraddr", mAddr, 32'h244);
        check("ab_wrdata", mWdata, exp_mem[widx(32'h204)]);
        mGnt = 1'b0;
        cfg_write(32'hC, {28'd0, ie_sh, 3'b100});
        check_status("ab_after", 1'b0, 1'b0);
        check("ab_mReq", 32'(mReq), 32'd0);
        mGnt = 1'b1;
        repeat (3) tick();
        check_result("ab");

        // Source address wrap
        fill_and_snapshot();
        prog(32'hFFFF_FFFC, 32'h100, 2);
        model_copy(32'hFFFF_FFFC, 32'h100, 2);
        mGnt = 1'b1;
        start_xfer();
        wait_done(1'b0, cyc);
        check("w_cycles", 32'(cyc), 32'd5);
        check("w_rd2", (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_BEEF, 32'h0000_0000);
        check_result("w");
        cfg_write(32'hC, {28'd0, ie_sh, 3'b010});

        // Reset in the middle of a transfer
        fill_and_snapshot();
        prog(32'h200, 32'h240, 4);
        mGnt = 1'b1;
        start_xfer();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("r_mReq", 32'(mReq), 32'd0);
        check("r_mWe", 32'(mWe), 32'd0);
        check("r_mAddr", mAddr, 32'd0);
        tick();
        rd_reg(32'h0, v); check("r_src", v, 32'd0);
        rd_reg(32'h8, v); check("r_len", v, 32'd0);
        reset = 1'b1;
        ie_sh = 1'b0;
        tick();
        check_status("r_idle", 1'b0, 1'b0);
        check("r_nwr", 32'(wr_q.size()), 32'd1);

        // Randomized transfers, some with random grant
        for (int t = 0; t < 8; t++) begin
            fill_and_snapshot();
            s = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            n = $urandom_range(1, 8);
            ie_sh = 1'($urandom_range(0, 1));
            rnd = (t >= 3);
            prog(s, d, n);
            model_copy(s, d, n);
            mGnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_xfer();
            mGnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_write(32'h0, ~s);
            mGnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_write(32'hC, {28'd0, ie_sh, 3'b001});
            wait_done(rnd, cyc);
            if (!rnd) check("x_cycles", 32'(cyc + 2), 32'(2 * n + 1));
            check_status("x_end", 1'b0, 1'b1);
            check_result("x");
            rd_reg(32'h0, v); check("x_src_rb", v, s);
            rd_reg(32'h8, v); check("x_len_rb", v, 32'(n));
            cfg_write(32'hC, {28'd0, ie_sh, 3'b010});
            check_status("x_clr", 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
